// File: rtl/time_set_ctrl_pkg.sv
// Shared mode encodings, field widths and field limits for the clock controller.
// Also holds the wrap-around increment helpers used by the run and edit paths.
package clock_pkg;

  localparam int HOUR_W   = 5;
  localparam int MINSEC_W = 6;

  localparam logic [HOUR_W-1:0]   HOUR_MAX   = 5'd23;
  localparam logic [MINSEC_W-1:0] MINSEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_e;

  // Wrap on equality with the maximum so a field never leaves its legal range.
  function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
    return (h == HOUR_MAX) ? '0 : h + 1'b1;
  endfunction

  function automatic logic [MINSEC_W-1:0] minsec_inc(input logic [MINSEC_W-1:0] v);
    return (v == MINSEC_MAX) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button inputs and time/display outputs of the clock controller.
interface time_set_ctrl_if;
  import clock_pkg::*;

  logic                btn_mode;
  logic                btn_inc;
  logic [HOUR_W-1:0]   hour;
  logic [MINSEC_W-1:0] min;
  logic [MINSEC_W-1:0] sec;
  logic [1:0]          mode;
  logic                blink;
  logic                tick_1hz;

  modport master (
    output btn_mode, btn_inc,
    input  hour, min, sec, mode, blink, tick_1hz
  );

  modport slave (
    input  btn_mode, btn_inc,
    output hour, min, sec, mode, blink, tick_1hz
  );

endinterface

// File: rtl/time_set_ctrl_tick_gen.sv
// Prescaler producing a one-cycle 1 Hz enable and a 2 Hz half-tick enable.
// Both enables are registered and line up with the counter value they decode.
module tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic half_tick
);

  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2 - 1);

  logic [CW-1:0] pcnt_reg;
  logic [CW-1:0] pcnt_next;

  always_comb begin
    pcnt_next = pcnt_reg + 1'b1;
    if (clr || pcnt_reg == LAST)
      pcnt_next = '0;
  end

  // Enables are computed from the next count so they are high while pcnt holds that value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_reg  <= '0;
      tick      <= 1'b0;
      half_tick <= 1'b0;
    end else begin
      pcnt_reg  <= pcnt_next;
      tick      <= (pcnt_next == LAST);
      half_tick <= (pcnt_next == LAST) || (pcnt_next == HALF);
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time-keeping and button-driven time-set controller.
// Holds the mode FSM, the hh:mm:ss registers with carry chain and the blink register.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input logic           clk,
  input logic           rst,
  time_set_ctrl_if.slave bus
);

  mode_e               mode_reg;
  logic                blink_reg;
  logic [HOUR_W-1:0]   hour_reg;
  logic [MINSEC_W-1:0] min_reg;
  logic [MINSEC_W-1:0] sec_reg;
  logic                tick;
  logic                half_tick;
  logic                edit_inc;
  logic                pcnt_clr;

  // A mode press always wins over a simultaneous increment press.
  assign edit_inc = bus.btn_inc && !bus.btn_mode;
  assign pcnt_clr = (mode_reg == MODE_SET_SEC) && (bus.btn_mode || bus.btn_inc);

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .clr       (pcnt_clr),
    .tick      (tick),
    .half_tick (half_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg  <= MODE_RUN;
      blink_reg <= 1'b1;
    end else if (bus.btn_mode) begin
      case (mode_reg)
        MODE_RUN:      begin mode_reg <= MODE_SET_HOUR; blink_reg <= 1'b1; end
        MODE_SET_HOUR: begin mode_reg <= MODE_SET_MIN;  blink_reg <= half_tick ? ~blink_reg : blink_reg; end
        MODE_SET_MIN:  begin mode_reg <= MODE_SET_SEC;  blink_reg <= half_tick ? ~blink_reg : blink_reg; end
        default:       begin mode_reg <= MODE_RUN;      blink_reg <= 1'b1; end
      endcase
    end else if (mode_reg == MODE_RUN) begin
      blink_reg <= 1'b1;
    end else if (half_tick) begin
      blink_reg <= ~blink_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hour_reg <= '0;
      min_reg  <= '0;
      sec_reg  <= '0;
    end else begin
      case (mode_reg)
        MODE_RUN: begin
          if (tick) begin
            sec_reg <= minsec_inc(sec_reg);
            if (sec_reg == MINSEC_MAX) begin
              min_reg <= minsec_inc(min_reg);
              if (min_reg == MINSEC_MAX)
                hour_reg <= hour_inc(hour_reg);
            end
          end
        end
        MODE_SET_HOUR: if (edit_inc) hour_reg <= hour_inc(hour_reg);
        MODE_SET_MIN:  if (edit_inc) min_reg  <= minsec_inc(min_reg);
        default:       if (edit_inc) sec_reg  <= '0;
      endcase
    end
  end

  assign bus.hour     = hour_reg;
  assign bus.min      = min_reg;
  assign bus.sec      = sec_reg;
  assign bus.mode     = mode_reg;
  assign bus.blink    = blink_reg;
  assign bus.tick_1hz = tick;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with CLK_HZ=10; each task checks its own scenario.
module tb_time_set_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  time_set_ctrl_if bus ();

  time_set_ctrl #(.CLK_HZ(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic pulse_mode();
    @(negedge clk); bus.btn_mode = 1'b1;
    @(negedge clk); bus.btn_mode = 1'b0;
  endtask

  task automatic pulse_inc_n(input int n);
    @(negedge clk); bus.btn_inc = 1'b1;
    repeat (n) @(negedge clk);
    bus.btn_inc = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    @(negedge clk); rst = 1'b1; #2;
    checks++; if (bus.hour !== 5'd0) begin failures++; $display("FAIL reset_hour got=%0d exp=0", bus.hour); end
    checks++; if (bus.min !== 6'd0) begin failures++; $display("FAIL reset_min got=%0d exp=0", bus.min); end
    checks++; if (bus.sec !== 6'd0) begin failures++; $display("FAIL reset_sec got=%0d exp=0", bus.sec); end
    checks++; if (bus.mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", bus.mode); end
    checks++; if (bus.blink !== 1'b1) begin failures++; $display("FAIL reset_blink got=%b exp=1", bus.blink); end
    checks++; if (bus.tick_1hz !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", bus.tick_1hz); end
    $display("test_reset done");
  endtask

  task automatic test_free_run();
    int   cnt;
    logic exp_tick;
    @(negedge clk); rst = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      exp_tick = (i == 9) || (i == 19);
      checks++;
      if (bus.tick_1hz !== exp_tick) begin
        failures++; $display("FAIL free_run_tick cycle=%0d got=%b exp=%b", i + 1, bus.tick_1hz, exp_tick);
      end
    end
    checks++; if (bus.sec !== 6'd2) begin failures++; $display("FAIL free_run_sec got=%0d exp=2", bus.sec); end
    checks++; if (bus.blink !== 1'b1) begin failures++; $display("FAIL free_run_blink got=%b exp=1", bus.blink); end
    checks++; if (bus.mode !== 2'd0) begin failures++; $display("FAIL free_run_mode got=%0d exp=0", bus.mode); end
    pulse_inc_n(1);
    checks++; if (bus.hour !== 5'd0 || bus.min !== 6'd0 || bus.sec !== 6'd2) begin
      failures++; $display("FAIL run_inc_ignored got=%0d:%0d:%0d exp=0:0:2", bus.hour, bus.min, bus.sec);
    end
    cnt = 0;
    while (!bus.tick_1hz && cnt < 20) begin @(negedge clk); cnt++; end
    checks++; if (!bus.tick_1hz) begin failures++; $display("FAIL run_tick_wait got=timeout exp=tick"); end
    bus.btn_mode = 1'b1;
    @(negedge clk); bus.btn_mode = 1'b0;
    checks++; if (bus.mode !== 2'd1) begin failures++; $display("FAIL tick_mode_mode got=%0d exp=1", bus.mode); end
    checks++; if (bus.sec !== 6'd3) begin failures++; $display("FAIL tick_mode_sec got=%0d exp=3", bus.sec); end
    checks++; if (bus.blink !== 1'b1) begin failures++; $display("FAIL tick_mode_blink got=%b exp=1", bus.blink); end
    $display("test_free_run done");
  endtask

  task automatic test_set_hour();
    do_reset();
    pulse_mode();
    pulse_inc_n(25);
    checks++; if (bus.mode !== 2'd1) begin failures++; $display("FAIL set_hour_mode got=%0d exp=1", bus.mode); end
    checks++; if (bus.hour !== 5'd1) begin failures++; $display("FAIL set_hour_hour got=%0d exp=1", bus.hour); end
    checks++; if (bus.min !== 6'd0 || bus.sec !== 6'd0) begin
      failures++; $display("FAIL set_hour_minsec got=%0d:%0d exp=0:0", bus.min, bus.sec);
    end
    $display("test_set_hour done");
  endtask

  task automatic test_set_min();
    logic prev;
    int   toggles;
    int   last;
    int   gap_bad;
    do_reset();
    pulse_mode();
    pulse_mode();
    pulse_inc_n(60);
    checks++; if (bus.mode !== 2'd2) begin failures++; $display("FAIL set_min_mode got=%0d exp=2", bus.mode); end
    checks++; if (bus.min !== 6'd0) begin failures++; $display("FAIL set_min_min got=%0d exp=0", bus.min); end
    checks++; if (bus.hour !== 5'd0) begin failures++; $display("FAIL set_min_nocarry got=%0d exp=0", bus.hour); end
    prev = bus.blink; toggles = 0; last = -1; gap_bad = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.blink !== prev) begin
        if (last >= 0 && (i - last) != 5) gap_bad++;
        last = i;
        toggles++;
      end
      prev = bus.blink;
    end
    checks++; if (toggles != 4) begin failures++; $display("FAIL set_min_blink_count got=%0d exp=4", toggles); end
    checks++; if (gap_bad != 0) begin failures++; $display("FAIL set_min_blink_gap got=%0d exp=0", gap_bad); end
    checks++; if (bus.sec !== 6'd0) begin failures++; $display("FAIL set_min_sec_frozen got=%0d exp=0", bus.sec); end
    $display("test_set_min done");
  endtask

  task automatic test_wrap();
    do_reset();
    pulse_mode();
    pulse_inc_n(23);
    pulse_mode();
    pulse_inc_n(59);
    pulse_mode();
    checks++; if (bus.hour !== 5'd23 || bus.min !== 6'd59 || bus.mode !== 2'd3) begin
      failures++; $display("FAIL wrap_preload got=%0d:%0d mode=%0d exp=23:59 mode=3", bus.hour, bus.min, bus.mode);
    end
    @(negedge clk); bus.btn_mode = 1'b1;
    @(posedge clk); #1; bus.btn_mode = 1'b0;
    repeat (599) begin @(posedge clk); #1; end
    checks++; if (bus.hour !== 5'd23 || bus.min !== 6'd59 || bus.sec !== 6'd59) begin
      failures++; $display("FAIL wrap_before got=%0d:%0d:%0d exp=23:59:59", bus.hour, bus.min, bus.sec);
    end
    checks++; if (bus.tick_1hz !== 1'b1) begin failures++; $display("FAIL wrap_tick got=%b exp=1", bus.tick_1hz); end
    @(posedge clk); #1;
    checks++; if (bus.hour !== 5'd0 || bus.min !== 6'd0 || bus.sec !== 6'd0) begin
      failures++; $display("FAIL wrap_after got=%0d:%0d:%0d exp=0:0:0", bus.hour, bus.min, bus.sec);
    end
    $display("test_wrap done");
  endtask

  task automatic test_sec_clear();
    int cnt;
    do_reset();
    repeat (370) @(posedge clk);
    #1;
    pulse_mode(); pulse_mode(); pulse_mode();
    checks++; if (bus.sec !== 6'd37 || bus.mode !== 2'd3) begin
      failures++; $display("FAIL sec_preload got=%0d mode=%0d exp=37 mode=3", bus.sec, bus.mode);
    end
    pulse_inc_n(1);
    checks++; if (bus.sec !== 6'd0) begin failures++; $display("FAIL sec_clear got=%0d exp=0", bus.sec); end
    cnt = 0;
    while (!bus.tick_1hz && cnt < 30) begin @(negedge clk); cnt++; end
    checks++; if (cnt != 9) begin failures++; $display("FAIL sec_clear_pcnt got=%0d exp=9", cnt); end
    bus.btn_mode = 1'b1;
    @(negedge clk); bus.btn_mode = 1'b0;
    checks++; if (bus.mode !== 2'd0 || bus.sec !== 6'd0) begin
      failures++; $display("FAIL sec_exit got=mode%0d sec%0d exp=mode0 sec0", bus.mode, bus.sec);
    end
    cnt = 1;
    while (!bus.tick_1hz && cnt < 30) begin @(negedge clk); cnt++; end
    checks++; if (cnt != 10) begin failures++; $display("FAIL sec_exit_next_tick got=%0d exp=10", cnt); end
    checks++; if (bus.sec !== 6'd0) begin failures++; $display("FAIL sec_exit_noinc got=%0d exp=0", bus.sec); end
    $display("test_sec_clear done");
  endtask

  task automatic test_simul_rst();
    do_reset();
    @(negedge clk); bus.btn_mode = 1'b1; bus.btn_inc = 1'b1;
    @(negedge clk); bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    checks++; if (bus.mode !== 2'd1 || bus.hour !== 5'd0) begin
      failures++; $display("FAIL simul_press got=mode%0d hour%0d exp=mode1 hour0", bus.mode, bus.hour);
    end
    pulse_inc_n(3);
    pulse_mode();
    pulse_inc_n(5);
    checks++; if (bus.hour !== 5'd3 || bus.min !== 6'd5 || bus.mode !== 2'd2) begin
      failures++; $display("FAIL pre_rst got=%0d:%0d mode=%0d exp=3:5 mode=2", bus.hour, bus.min, bus.mode);
    end
    #2; rst = 1'b1; #1;
    checks++; if (bus.hour !== 5'd0 || bus.min !== 6'd0 || bus.sec !== 6'd0) begin
      failures++; $display("FAIL async_rst_time got=%0d:%0d:%0d exp=0:0:0", bus.hour, bus.min, bus.sec);
    end
    checks++; if (bus.mode !== 2'd0 || bus.blink !== 1'b1 || bus.tick_1hz !== 1'b0) begin
      failures++; $display("FAIL async_rst_ctl got=mode%0d blink%b tick%b exp=mode0 blink1 tick0", bus.mode, bus.blink, bus.tick_1hz);
    end
    @(negedge clk); rst = 1'b0;
    $display("test_simul_rst done");
  endtask

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    test_reset();
    test_free_run();
    test_set_hour();
    test_set_min();
    test_wrap();
    test_sec_clear();
    test_simul_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
